// File: rtl/ps2_pkg.sv
// ps2_pkg: shared prefix codes, decoder states and the key-event record.
package ps2_pkg;
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous first-word-fall-through FIFO; the caller never pushes
// when full without a same-cycle pop, and never pops when empty.
module key_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    // Extra pointer bit tells a full ring from an empty one.
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_key_event.sv
// ps2_key_event: drains PS/2 scan-code bytes, folds E0/F0 prefixes into key events,
// tracks the held key, counts fresh presses in BCD and queues events in a FIFO.
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_DIGITS      = 2,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_ready,
    input  logic [7:0]              ps2_byte,
    output logic                    ps2_nextdata_n,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [7:0]              evt_code,
    output logic                    evt_ext,
    output logic                    evt_break,
    output logic                    key_held,
    output logic [8:0]              held_code,
    output logic [4*CNT_DIGITS-1:0] press_bcd,
    output logic                    overflow
);
    state_t state;
    logic accept, is_e0, is_f0, emit, ext, brk, rpt, enq, push, pop, full, empty, c;
    logic [8:0] key;
    logic [4*CNT_DIGITS-1:0] bcd_nxt;
    evt_t evt_in, head;

    assign accept = ps2_ready & ps2_nextdata_n;
    assign is_e0  = ps2_byte == PS2_PFX_EXT;
    assign is_f0  = ps2_byte == PS2_PFX_BRK;
    assign emit   = accept & ~is_e0 & ~is_f0;
    assign ext    = (state == EXT) || (state == EXT_BRK);
    assign brk    = (state == BRK) || (state == EXT_BRK);
    assign key    = {ext, ps2_byte};
    assign rpt    = key_held && (key == held_code);
    assign enq    = emit & (brk | ~rpt | (SUPPRESS_REPEAT == 0));
    assign pop    = ~empty & evt_ready;
    assign push   = enq & (~full | pop);
    assign evt_in = evt_t'({ext, brk, ps2_byte});

    always_comb begin
        bcd_nxt = press_bcd;
        c = 1'b1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            bcd_nxt[4*i +: 4] = c ? ((press_bcd[4*i +: 4] == 4'd9) ? 4'd0 : press_bcd[4*i +: 4] + 4'd1)
                                  : press_bcd[4*i +: 4];
            c = c & (press_bcd[4*i +: 4] == 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ps2_nextdata_n <= 1'b1;
            key_held       <= 1'b0;
            held_code      <= '0;
            press_bcd      <= '0;
            overflow       <= 1'b0;
        end else begin
            ps2_nextdata_n <= ~accept;
            // Non-emitting bytes are prefixes: only IDLE and EXT advance, others hold.
            if (accept)
                state <= emit ? IDLE :
                         (state == IDLE && is_e0) ? EXT :
                         (state == IDLE) ? BRK :
                         (state == EXT && is_f0) ? EXT_BRK : state;
            if (emit && !brk && !rpt) begin
                key_held  <= 1'b1;
                held_code <= key;
                press_bcd <= bcd_nxt;
            end
            if (emit && brk && key == held_code) begin
                key_held  <= 1'b0;
                held_code <= '0;
            end
            if (enq && !push) overflow <= 1'b1;
        end
    end

    key_evt_fifo #(.WIDTH($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (evt_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt_valid = ~empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
endmodule

// File: tb/tb_ps2_key_event.sv
// tb_ps2_key_event: drives two decoders (repeat suppression on and off) with the same
// byte stream and compares events and key state against a prefix-flag reference model.
module tb_ps2_key_event;
    localparam int DEPTH = 8;
    localparam int MOD   = 100;

    logic clk = 0, rst = 1, ps2_ready = 0, evt_ready = 0;
    logic [7:0] ps2_byte = 0;
    logic nd0, v0, x0, b0, h0, o0, nd1, v1, x1, b1, h1, o1;
    logic [7:0] c0, c1, bcd0, bcd1;
    logic [8:0] hc0, hc1;

    always #5 clk = ~clk;

    ps2_key_event #(.FIFO_DEPTH(DEPTH), .CNT_DIGITS(2), .SUPPRESS_REPEAT(1)) dut0 (
        .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_byte(ps2_byte), .ps2_nextdata_n(nd0),
        .evt_valid(v0), .evt_ready(evt_ready), .evt_code(c0), .evt_ext(x0), .evt_break(b0),
        .key_held(h0), .held_code(hc0), .press_bcd(bcd0), .overflow(o0));
    ps2_key_event #(.FIFO_DEPTH(DEPTH), .CNT_DIGITS(2), .SUPPRESS_REPEAT(0)) dut1 (
        .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_byte(ps2_byte), .ps2_nextdata_n(nd1),
        .evt_valid(v1), .evt_ready(evt_ready), .evt_code(c1), .evt_ext(x1), .evt_break(b1),
        .key_held(h1), .held_code(hc1), .press_bcd(bcd1), .overflow(o1));

    int checks = 0, failures = 0, low_cnt = 0;
    logic [9:0] exp0[$], exp1[$], obs0[$], obs1[$];
    bit pe, pb;
    bit held[2], ovf[2];
    logic [8:0] hcode[2];
    int cnt[2], occ[2];

    always @(negedge clk) begin
        if (v0 && evt_ready) obs0.push_back({x0, b0, c0});
        if (v1 && evt_ready) obs1.push_back({x1, b1, c1});
        if (!nd0) low_cnt++;
    end

    function automatic logic [7:0] to_bcd(int n);
        return 8'(((n / 10) % 10) * 16 + n % 10);
    endfunction

    function automatic bit q_eq(logic [9:0] a[$], logic [9:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [9:0] ev;
        logic [8:0] k;
        bit rep, enq;
        if (b == 8'hE0) begin
            if (!pb) pe = 1;
        end else if (b == 8'hF0) begin
            pb = 1;
        end else begin
            ev = {pe, pb, b};
            k  = {pe, b};
            for (int m = 0; m < 2; m++) begin
                rep = !pb && held[m] && k == hcode[m];
                if (!pb && !rep) begin
                    held[m] = 1; hcode[m] = k; cnt[m] = (cnt[m] + 1) % MOD;
                end
                if (pb && k == hcode[m]) begin
                    held[m] = 0; hcode[m] = 0;
                end
                enq = pb || !rep || m == 1;
                if (enq) begin
                    if (!evt_ready && occ[m] == DEPTH) ovf[m] = 1;
                    else begin
                        if (!evt_ready) occ[m]++;
                        if (m == 0) exp0.push_back(ev); else exp1.push_back(ev);
                    end
                end
            end
            pe = 0; pb = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        ps2_byte = b;
        ps2_ready = 1;
        do begin @(posedge clk); #1; t++; end while (nd0 !== 1'b0 && t < 20);
        ps2_ready = 0;
        if (t >= 20) begin
            checks++; failures++;
            $display("FAIL accept_timeout byte=%h nextdata_n=%b required=0", b, nd0);
        end
        model_byte(b);
        @(posedge clk); #1;
    endtask

    task automatic do_rst();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        pe = 0; pb = 0;
        for (int m = 0; m < 2; m++) begin
            held[m] = 0; ovf[m] = 0; hcode[m] = 0; cnt[m] = 0; occ[m] = 0;
        end
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_rst();
        checks++;
        if ({nd0, v0, h0, hc0, bcd0, o0} !== {1'b1, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset dut0 got nd=%b v=%b held=%b hc=%h bcd=%h ovf=%b required 1 0 0 000 00 0",
                     nd0, v0, h0, hc0, bcd0, o0);
        end
        checks++;
        if ({nd1, v1, h1, hc1, bcd1, o1} !== {1'b1, 1'b0, 1'b0, 9'h0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset dut1 got nd=%b v=%b held=%b hc=%h bcd=%h ovf=%b", nd1, v1, h1, hc1, bcd1, o1);
        end
    endtask

    task automatic test_basic();
        int l;
        do_rst();
        evt_ready = 1;
        l = low_cnt;
        send(8'h1C); send(8'hF0); send(8'h1C);
        settle();
        checks++;
        if (obs0.size() != 2 || obs0[0] !== 10'h01C || obs0[1] !== 10'h11C) begin
            failures++;
            $display("FAIL basic_events got n=%0d e0=%h e1=%h required 2 01c 11c", obs0.size(), obs0[0], obs0[1]);
        end
        checks++;
        if (!q_eq(obs1, exp1)) begin
            failures++;
            $display("FAIL basic_events_nr got n=%0d required n=%0d", obs1.size(), exp1.size());
        end
        checks++;
        if (bcd0 !== 8'h01 || h0 !== 1'b0) begin
            failures++;
            $display("FAIL basic_state got bcd=%h held=%b required 01 0", bcd0, h0);
        end
        checks++;
        if (low_cnt - l != 3) begin
            failures++;
            $display("FAIL nextdata_pulses got low_cycles=%0d required 3", low_cnt - l);
        end
    endtask

    task automatic test_ext();
        do_rst();
        evt_ready = 1;
        send(8'hE0); send(8'h75);
        checks++;
        if (hc0 !== 9'h175 || h0 !== 1'b1) begin
            failures++;
            $display("FAIL ext_held got hc=%h held=%b required 175 1", hc0, h0);
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        settle();
        checks++;
        if (obs0.size() != 2 || obs0[0] !== 10'h275 || obs0[1] !== 10'h375) begin
            failures++;
            $display("FAIL ext_events got n=%0d e0=%h e1=%h required 2 275 375", obs0.size(), obs0[0], obs0[1]);
        end
        checks++;
        if (hc0 !== 9'h0 || h0 !== 1'b0) begin
            failures++;
            $display("FAIL ext_release got hc=%h held=%b required 000 0", hc0, h0);
        end
    endtask

    task automatic test_repeat();
        do_rst();
        evt_ready = 1;
        repeat (5) send(8'h1C);
        send(8'hF0); send(8'h1C);
        settle();
        checks++;
        if (obs0.size() != 2 || !q_eq(obs0, exp0)) begin
            failures++;
            $display("FAIL repeat_suppressed got n=%0d required 2", obs0.size());
        end
        checks++;
        if (obs1.size() != 6 || !q_eq(obs1, exp1)) begin
            failures++;
            $display("FAIL repeat_passed got n=%0d required 6", obs1.size());
        end
        checks++;
        if (bcd0 !== 8'h01 || bcd1 !== 8'h01) begin
            failures++;
            $display("FAIL repeat_count got bcd0=%h bcd1=%h required 01 01", bcd0, bcd1);
        end
    endtask

    task automatic test_counter();
        do_rst();
        evt_ready = 1;
        repeat (99) begin send(8'h16); send(8'hF0); send(8'h16); end
        checks++;
        if (bcd0 !== 8'h99 || bcd1 !== 8'h99) begin
            failures++;
            $display("FAIL count_99 got bcd0=%h bcd1=%h required 99", bcd0, bcd1);
        end
        send(8'h16); send(8'hF0); send(8'h16);
        settle();
        checks++;
        if (bcd0 !== 8'h00 || o0 !== 1'b0 || o1 !== 1'b0) begin
            failures++;
            $display("FAIL count_wrap got bcd=%h ovf0=%b ovf1=%b required 00 0 0", bcd0, o0, o1);
        end
        checks++;
        if (!q_eq(obs0, exp0) || !q_eq(obs1, exp1)) begin
            failures++;
            $display("FAIL count_events got n0=%0d n1=%0d required %0d %0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] c, prev;
        do_rst();
        evt_ready = 0;
        prev = 0;
        repeat (9) begin
            do c = 8'($urandom_range(1, 8'hDF)); while (c == prev);
            prev = c;
            send(c);
        end
        checks++;
        if (v0 !== 1'b1 || o0 !== 1'b1 || o1 !== 1'b1 || ovf[0] != 1) begin
            failures++;
            $display("FAIL overflow_flag got v=%b ovf0=%b ovf1=%b required 1 1 1", v0, o0, o1);
        end
        evt_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (obs0.size() != 8 || !q_eq(obs0, exp0) || !q_eq(obs1, exp1)) begin
            failures++;
            $display("FAIL overflow_drain got n0=%0d n1=%0d required 8 8 in order", obs0.size(), obs1.size());
        end
        checks++;
        if (bcd0 !== to_bcd(cnt[0]) || v0 !== 1'b0) begin
            failures++;
            $display("FAIL overflow_count got bcd=%h v=%b required %h 0", bcd0, v0, to_bcd(cnt[0]));
        end
        evt_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_rst();
        evt_ready = 1;
        send(8'hE0); send(8'hF0);
        do_rst();
        checks++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_empty got v0=%b v1=%b required 0 0", v0, v1);
        end
        send(8'h1C);
        settle();
        checks++;
        if (obs0.size() != 1 || obs0[0] !== 10'h01C || bcd0 !== 8'h01 || o0 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_event got n=%0d e=%h bcd=%h ovf=%b required 1 01c 01 0",
                     obs0.size(), obs0[0], bcd0, o0);
        end
    endtask

    task automatic test_random();
        logic [7:0] tbl [5];
        int r;
        tbl = '{8'h1C, 8'h75, 8'h16, 8'h29, 8'h5A};
        do_rst();
        evt_ready = 1;
        repeat (300) begin
            r = $urandom_range(0, 99);
            send(r < 15 ? 8'hE0 : r < 35 ? 8'hF0 : r < 85 ? tbl[$urandom_range(0, 4)] : 8'($urandom_range(1, 8'hDF)));
        end
        settle();
        checks++;
        if (!q_eq(obs0, exp0) || !q_eq(obs1, exp1)) begin
            failures++;
            $display("FAIL random_events got n0=%0d n1=%0d required %0d %0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
        end
        checks++;
        if (h0 !== held[0] || hc0 !== hcode[0] || bcd0 !== to_bcd(cnt[0]) || o0 !== 1'b0) begin
            failures++;
            $display("FAIL random_state0 got held=%b hc=%h bcd=%h ovf=%b required %b %h %h 0",
                     h0, hc0, bcd0, o0, held[0], hcode[0], to_bcd(cnt[0]));
        end
        checks++;
        if (h1 !== held[1] || hc1 !== hcode[1] || bcd1 !== to_bcd(cnt[1]) || o1 !== 1'b0) begin
            failures++;
            $display("FAIL random_state1 got held=%b hc=%h bcd=%h ovf=%b required %b %h %h 0",
                     h1, hc1, bcd1, o1, held[1], hcode[1], to_bcd(cnt[1]));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_ext();
        test_repeat();
        test_counter();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
- Sits between the PS/2 byte receiver (ps2_keyboard) and display/ASCII consumers.
- Drains received scan-code bytes using the receiver's ready/nextdata_n handshake.
- Decodes E0 (extended) and F0 (break) prefixes into complete key events and buffers them in a parametrised FIFO with valid/ready output.
- Also keeps held-key state, suppresses typematic repeats, and maintains a BCD press counter for the seven-segment digits.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- CNT_DIGITS, 2, BCD digits in the press counter.
- SUPPRESS_REPEAT, 1, when 1, repeated makes of the held key are not enqueued.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- ps2_ready  in  1  receiver has a byte available.
- ps2_byte  in  8  receiver byte.
- ps2_nextdata_n  out  1  active-low byte-consumed strobe to the receiver.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_code  out  8  head scan code.
- evt_ext  out  1  head was E0-prefixed.
- evt_break  out  1  head is a release.
- key_held  out  1  a key is currently held.
- held_code  out  9  {ext, code} of held key.
- press_bcd  out  4*CNT_DIGITS  BCD count of fresh presses; digit 0 in [3:0].
- overflow  out  1  sticky: an event was dropped on a full FIFO.

Behaviour:
- Reset values:
  - ps2_nextdata_n=1.
  - evt_valid=0; FIFO empty.
  - key_held=0, held_code=0.
  - press_bcd=0.
  - overflow=0.
  - FSM in IDLE.
  - Reset mid-sequence discards any partial prefix.
- Byte acceptance:
  - A byte is accepted in a cycle where ps2_ready=1 and ps2_nextdata_n=1.
  - ps2_nextdata_n is registered low for exactly the following cycle, then returns to 1.
  - No byte is accepted while it is low, so back-to-back accepts are at least 2 cycles apart and the same byte is never consumed twice.
- FSM states: IDLE, EXT, BRK, EXT_BRK. On an accepted byte:
  - IDLE: E0 -> EXT; F0 -> BRK; else emit make{ext=0}, -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; else emit make{ext=1}, -> IDLE.
  - BRK: E0/F0 -> BRK (ignored); else emit break{ext=0}, -> IDLE.
  - EXT_BRK: E0/F0 -> EXT_BRK (ignored); else emit break{ext=1}, -> IDLE.
  - Emission happens in the same cycle as acceptance; its effects become visible next cycle.
- Make handling:
  - Repeat: key_held=1 and {ext,code}==held_code. No counter change. Enqueued only if SUPPRESS_REPEAT=0.
  - Fresh make: held_code<={ext,code}, key_held<=1, press_bcd increments, event enqueued.
- Break handling:
  - Always enqueued.
  - Clears key_held and held_code only if {ext,code}==held_code; otherwise held state is unchanged.
- press_bcd:
  - Ripple BCD increment; each digit wraps 9->0 with a carry.
  - All-9s wraps to all-0s; overflow is not affected by this wrap.
- FIFO:
  - First-word-fall-through; evt_* show the head whenever evt_valid=1.
  - Pop on evt_valid & evt_ready.
  - Push when an event is emitted and the FIFO is not full, or it is full but a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow<=1, held until rst.
  - Held state and the counter update even when the event is dropped.
  - Simultaneous push and pop keeps the occupancy constant.
  - Empty plus push makes evt_valid high the next cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package ps2_pkg:
  - PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0.
  - FSM state enum.
  - Event record {ext, brk, code[7:0]} (10 bits).
- Sub-module key_evt_fifo:
  - Parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with full/empty flags.
  - The top level holds the FSM, held-key logic, BCD counter and handshake.

Test Plan:
- Bytes 1C, F0, 1C; evt_ready=1:
  - events {code=1C, brk=0, ext=0} then {1C, brk=1, ext=0}.
  - press_bcd=0x01; key_held ends 0.
  - ps2_nextdata_n is one 1-cycle low pulse per byte.
- Bytes E0, 75, E0, F0, 75:
  - events {75, ext=1, brk=0} then {75, ext=1, brk=1}.
  - held_code=0x175 between the two events, then 0.
- Byte 1C x5 then F0, 1C with SUPPRESS_REPEAT=1:
  - 2 events total; press_bcd=0x01.
  - With SUPPRESS_REPEAT=0: 6 events, press_bcd still 0x01.
- 99 fresh press/release pairs of code 16 with CNT_DIGITS=2:
  - press_bcd=0x99.
  - One more pair: press_bcd=0x00, overflow=0.
- FIFO_DEPTH=8, evt_ready=0, 9 fresh makes:
  - 8 entries held, overflow=1.
  - Raising evt_ready drains exactly 8 events in order.
- Bytes E0, F0 then rst for 1 cycle, then byte 1C:
  - FIFO empty after reset; then event {1C, ext=0, brk=0}.
  - press_bcd=0x01, overflow=0.
